hilo_mdu: RTL
=============

# hilo_mdu

Multi-cycle multiply/accumulate unit that owns the architectural HI and LO registers and sits directly downstream of the datapath ALU. It executes MULT, MULTU, MADD, MADDU, MTHI and MTLO on the register-file operands and holds the 64-bit result in HI/LO for MFHI/MFLO reads. It also asserts `busy`, which the control unit uses to stall the single-cycle core while an iterative multiply is in flight.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits; the product is 2×`WIDTH`.

Ports:
- `clk`: input, 1 bit. Rising-edge clock.
- `reset`: input, 1 bit. Asynchronous, active-high reset.
- `start`: input, 1 bit. Operation request; sampled only in IDLE.
- `op`: input, 3 bits. Operation code: 0 NOP, 1 MULT, 2 MULTU, 3 MADD, 4 MADDU, 5 MTHI, 6 MTLO, 7 reserved.
- `rs_val`: input, `WIDTH` bits. Operand A; also the source for MTHI/MTLO.
- `rt_val`: input, `WIDTH` bits. Operand B.
- `busy`: output, 1 bit. High while a multiply is in flight; the core must stall.
- `done`: output, 1 bit. One-cycle pulse on the cycle HI/LO take the multiply result.
- `hi`: output, `WIDTH` bits. Architectural HI register.
- `lo`: output, `WIDTH` bits. Architectural LO register.

## Operation
- States: IDLE, MUL, FIN.
- IDLE, `start`=1:
  - op 1–4: latch operand magnitudes, latch the sign flag and the op, clear the counter and partial product, go to MUL.
  - op 5: HI←`rs_val`; stay in IDLE; no busy.
  - op 6: LO←`rs_val`; stay in IDLE; no busy.
  - op 0 or 7: ignored.
- Signed ops (MULT, MADD):
  - Operands are converted to magnitude.
  - Sign flag = A[W-1] XOR B[W-1].
  - Magnitude of 0x80000000 is 2^31 and must be treated as unsigned, so there is no overflow.
- MUL: radix-2 shift-add, one multiplier bit per cycle, LSB first, for exactly `WIDTH` cycles. The counter is $clog2(`WIDTH`) bits, and the last iteration is counter = `WIDTH`-1. Then go to FIN.
- FIN:
  - Negate the 64-bit product (two's complement) if the sign flag is set.
  - MADD/MADDU: {HI,LO} ← {HI,LO} + product, modulo 2^(2·`WIDTH`), with carry from LO into HI.
  - MULT/MULTU: {HI,LO} ← product.
  - Pulse `done`, return to IDLE.
- `start` while state ≠ IDLE: ignored. No queueing, no error.
- HI/LO change only on MTHI/MTLO or at FIN. MFHI/MFLO read `hi`/`lo` combinationally through the core's writeback mux.
- Operands are latched at acceptance; changes on `rs_val`/`rt_val` during MUL have no effect.

## Timing
- Reset (asynchronous assert, any state): `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE. An in-flight multiply is discarded and HI/LO are not written.
- Edge E0: `start` with a multiply op is accepted; `busy`=1 from after E0.
- Edges E1..E32: MUL iterations. At E32, state → FIN.
- Edge E33: HI/LO written, `done`=1 for one cycle, `busy`=0, state → IDLE.
- Total busy time is `WIDTH`+1 cycles (33 for `WIDTH`=32).
- A new `start` is accepted in the `done` cycle (IDLE). Back-to-back multiplies therefore issue every 34 cycles.
- MTHI/MTLO: `hi`/`lo` update at the accepting edge and are visible the next cycle. Zero stall.
- `done` is a registered output; `busy` is derived from state ≠ IDLE.

## Structure
- Shared package `mdu_pkg`: op encodings (`MDU_NOP`…`MDU_MTLO`), state enum (IDLE/MUL/FIN), and helper predicates `is_signed_op` and `is_acc_op`.
- One natural sub-module, `mdu_shift_add`: the iterative unsigned `WIDTH`×`WIDTH`→2·`WIDTH` core, with start/done and a counter. `hilo_mdu` wraps it with sign handling, the accumulate adder, the HI/LO registers and the top FSM.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: `busy` high 33 cycles, `done` at E33, HI=0xFFFFFFFE, LO=0x00000001.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- Sequence MTHI 0, MTLO 10 (each visible next cycle, no busy), then MADD 2 × 3 → HI=0, LO=16. Then MADD −1 × 20 → LO=0xFFFFFFFC, HI=0xFFFFFFFF.
- Carry wrap: HI=LO=0xFFFFFFFF, then MADDU 1 × 1 → HI=0, LO=0 (modulo wrap), `done` pulses once.
- Busy handling:
  - `start` with MTLO 0x55 at cycle 5 of a MULTU: ignored, LO equals the product afterwards.
  - Operand inputs toggled during MUL: result unchanged.
- Reset mid-operation: assert `reset` at cycle 10 of a MULT → `hi`=`lo`=0, `busy`=0 immediately. A following MULTU 6 × 7 gives LO=42, HI=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and op-class predicates shared by the HI/LO multiply unit
package mdu_pkg;
    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_MADD  = 3'd3,
        MDU_MADDU = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {IDLE, MUL, FIN} mdu_state_e;

    function automatic logic is_signed_op(input logic [2:0] op);
        return op == MDU_MULT || op == MDU_MADD;
    endfunction

    function automatic logic is_acc_op(input logic [2:0] op);
        return op == MDU_MADD || op == MDU_MADDU;
    endfunction
endpackage

// File: rtl/mdu_shift_add.sv
// mdu_shift_add: iterative radix-2 unsigned WIDTH x WIDTH multiplier, one multiplier bit per cycle, LSB first
//   i_start : load operands, clear counter and partial product
//   i_en    : perform one shift-add iteration
//   i_a/i_b : unsigned multiplicand / multiplier
//   o_prod  : 2*WIDTH-bit partial (final after WIDTH iterations) product
//   o_done  : high during the last iteration (counter = WIDTH-1)
module mdu_shift_add
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic                 i_en,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_prod,
    output logic                 o_done
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_prod   <= '0;
            r_mplier <= i_b;
            r_cnt    <= '0;
        end else if (i_en) begin
            r_prod   <= r_prod + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign o_prod = r_prod;
    assign o_done = i_en && r_cnt == CW'(WIDTH - 1);
endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu: multi-cycle multiply/accumulate unit owning the architectural HI/LO registers
//   clk, reset    : clock, asynchronous active-high reset
//   start, op     : operation request (sampled only in IDLE) and op code
//   rs_val/rt_val : operand A (also MTHI/MTLO source) / operand B
//   busy          : multiply in flight, core must stall
//   done          : one-cycle pulse after HI/LO take a multiply result
//   hi, lo        : architectural HI and LO registers
module hilo_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    mdu_state_e         r_state;
    mdu_state_e         w_next;
    logic [2:0]         r_op;
    logic               r_neg;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               w_accept;
    logic               w_mul_op;
    logic               w_sgn;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_mag_prod;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_result;
    logic               w_last;

    assign w_accept = start && r_state == IDLE;
    assign w_mul_op = op >= MDU_MULT && op <= MDU_MADDU;
    assign w_sgn    = is_signed_op(op);
    // The most negative value maps to 2^(WIDTH-1), which fits as an unsigned magnitude.
    assign w_a_mag  = (w_sgn && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign w_b_mag  = (w_sgn && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    mdu_shift_add #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .i_start(w_accept && w_mul_op),
        .i_en   (r_state == MUL),
        .i_a    (w_a_mag),
        .i_b    (w_b_mag),
        .o_prod (w_mag_prod),
        .o_done (w_last)
    );

    assign w_prod   = r_neg ? -w_mag_prod : w_mag_prod;
    assign w_result = is_acc_op(r_op) ? {r_hi, r_lo} + w_prod : w_prod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_accept && w_mul_op) ? MUL : IDLE;
            MUL:     w_next = w_last ? FIN : MUL;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op   <= MDU_NOP;
            r_neg  <= 1'b0;
            r_done <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= r_state == FIN;
            if (w_accept && w_mul_op) begin
                r_op  <= op;
                r_neg <= w_sgn && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            end
            if (r_state == FIN)
                {r_hi, r_lo} <= w_result;
            else if (w_accept && op == MDU_MTHI)
                r_hi <= rs_val;
            else if (w_accept && op == MDU_MTLO)
                r_lo <= rs_val;
        end
    end

    assign busy = r_state != IDLE;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule
